// File: rtl/traffic_pkg.sv
// Light encodings shared between the intersection controller and its front-end blocks.
package traffic_pkg;

   localparam int unsigned LightW = 3;

   typedef enum logic [LightW-1:0] {
      LightG = 3'b001,
      LightY = 3'b010,
      LightR = 3'b100
   } light_e;

   // Anything other than an exact green code counts as not served.
   function automatic logic is_green(input logic [LightW-1:0] light);
      return light == LightG;
   endfunction

endpackage

// File: rtl/demand_channel.sv
// One detector channel: two-flop sync, tick-based debounce, pending-request latch and
// stuck-presence monitor.
module demand_channel
   import traffic_pkg::*;
#(
   parameter int unsigned DEB_MS  = 20,
   parameter int unsigned STUCK_S = 300
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              det,
   input  logic              ms_tick,
   input  logic              sec_tick,
   input  logic [LightW-1:0] light,
   output logic              req,
   output logic              fault
);

   localparam int unsigned SW = $clog2(STUCK_S + 1);

   logic          sync1_q, sync2_q;
   logic          pres_q, pres_d;
   logic [7:0]    dcnt_q, dcnt_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic          req_q, req_d;
   logic          fault_q, fault_d;
   logic          served;

   always_comb begin
      served = is_green(light);

      pres_d = pres_q;
      dcnt_d = dcnt_q;
      if (sync2_q == pres_q) begin
         dcnt_d = '0;
      end else if (ms_tick) begin
         if (dcnt_q == 8'(DEB_MS - 1)) begin
            pres_d = ~pres_q;
            dcnt_d = '0;
         end else begin
            dcnt_d = dcnt_q + 8'd1;
         end
      end

      // Uses next-state presence so the count and fault drop on the same edge pres falls.
      scnt_d = scnt_q;
      if (!pres_d) begin
         scnt_d = '0;
      end else if (sec_tick && (scnt_q != SW'(STUCK_S))) begin
         scnt_d = scnt_q + SW'(1);
      end
      fault_d = (scnt_d == SW'(STUCK_S));

      req_d = req_q;
      if (served) begin
         req_d = 1'b0;
      end else if (pres_q || fault_q) begin
         req_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         pres_q  <= 1'b0;
         dcnt_q  <= '0;
         scnt_q  <= '0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         sync1_q <= det;
         sync2_q <= sync1_q;
         pres_q  <= pres_d;
         dcnt_q  <= dcnt_d;
         scnt_q  <= scnt_d;
         req_q   <= req_d;
         fault_q <= fault_d;
      end
   end

   assign req   = req_q;
   assign fault = fault_q;

endmodule

// File: rtl/traffic_demand_detector.sv
// Conditions the NS/EW loop detectors into pending demand for the intersection controller;
// owns the shared 1 ms / 1 s tick generator.
module traffic_demand_detector
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned DEB_MS   = 20,
   parameter int unsigned STUCK_S  = 300
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ns_det,
   input  logic              ew_det,
   input  logic [LightW-1:0] NS_str,
   input  logic [LightW-1:0] EW_str,
   output logic              ns,
   output logic              ew,
   output logic              ns_fault,
   output logic              ew_fault
);

   localparam int unsigned MsDiv = CLK_FREQ / 1000;
   localparam int unsigned MsW   = (MsDiv > 1) ? $clog2(MsDiv) : 1;

   logic [MsW-1:0] ms_cnt_q, ms_cnt_d;
   logic [9:0]     sec_cnt_q, sec_cnt_d;
   logic           ms_tick, sec_tick;

   always_comb begin
      ms_tick   = (ms_cnt_q == MsW'(MsDiv - 1));
      sec_tick  = ms_tick && (sec_cnt_q == 10'd999);
      ms_cnt_d  = ms_tick ? '0 : ms_cnt_q + MsW'(1);
      sec_cnt_d = sec_cnt_q;
      if (ms_tick) begin
         sec_cnt_d = sec_tick ? 10'd0 : sec_cnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ms_cnt_q  <= '0;
         sec_cnt_q <= '0;
      end else begin
         ms_cnt_q  <= ms_cnt_d;
         sec_cnt_q <= sec_cnt_d;
      end
   end

   demand_channel #(
      .DEB_MS  (DEB_MS),
      .STUCK_S (STUCK_S)
   ) u_ns (
      .clk      (clk),
      .rst      (rst),
      .det      (ns_det),
      .ms_tick  (ms_tick),
      .sec_tick (sec_tick),
      .light    (NS_str),
      .req      (ns),
      .fault    (ns_fault)
   );

   demand_channel #(
      .DEB_MS  (DEB_MS),
      .STUCK_S (STUCK_S)
   ) u_ew (
      .clk      (clk),
      .rst      (rst),
      .det      (ew_det),
      .ms_tick  (ms_tick),
      .sec_tick (sec_tick),
      .light    (EW_str),
      .req      (ew),
      .fault    (ew_fault)
   );

endmodule
